// File: rtl/block_serial_subtractor.sv
// block_serial_subtractor
// Computes diff = a - b - bin one BLOCK_SIZE-bit block per clock, lowest
// block first, with a valid/ready handshake on each side. A block whose
// operand bits are all equal forwards its incoming borrow directly. Those
// blocks are counted in skip_cnt.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready only while idle)
//   a, b, bin            minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake (out_valid only while done)
//   diff                 a - b - bin mod 2^DATA_WIDTH
//   bout                 final borrow-out
//   ovf                  signed overflow
//   zero                 diff == 0
//   skip_cnt             number of blocks that took the skip path
module block_serial_subtractor #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4,
  localparam int NUM_BLOCKS = (DATA_WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE,
  localparam int CNT_W = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  bout,
  output logic                  ovf,
  output logic                  zero,
  output logic [CNT_W-1:0]      skip_cnt
);

  // Operands are zero-padded to a whole number of blocks.
  localparam int PAD_W  = NUM_BLOCKS * BLOCK_SIZE;
  localparam int LAST_W = DATA_WIDTH - (NUM_BLOCKS - 1) * BLOCK_SIZE;
  localparam int IDX_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PAD_W-1:0]    a_sh;
  logic [PAD_W-1:0]    b_sh;
  logic [PAD_W-1:0]    diff_sh;
  logic [PAD_W-1:0]    diff_next;
  logic                br;
  logic [IDX_W-1:0]    idx;
  logic [BLOCK_SIZE-1:0] slice_d;
  logic                br_ripple;
  logic                br_out;
  logic                prop;
  logic                last_blk;

  assign last_blk = (idx == IDX_W'(NUM_BLOCKS - 1));

  // Block 0 is always at the bottom of the shift registers. The result
  // enters from the top, so block 0 ends up at the bottom after the last shift.
  assign diff_next = (diff_sh >> BLOCK_SIZE) | (PAD_W'(slice_d) << (PAD_W - BLOCK_SIZE));
  assign diff      = diff_sh[DATA_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The handshake outputs depend only on the registered state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_blk) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ripple-borrow subtraction of the current block. Padding bits of a
  // partial last block are excluded, so they stay zero in diff. They also
  // do not take part in the propagate term. The skip path forwards the
  // incoming borrow and gives the same value as the ripple chain.
  always_comb begin
    br_ripple = br;
    prop      = 1'b1;
    slice_d   = '0;
    for (int j = 0; j < BLOCK_SIZE; j++) begin
      if (!(last_blk && (j >= LAST_W))) begin
        slice_d[j] = a_sh[j] ^ b_sh[j] ^ br_ripple;
        br_ripple  = (~a_sh[j] & b_sh[j]) | (~(a_sh[j] ^ b_sh[j]) & br_ripple);
        prop       = prop & ~(a_sh[j] ^ b_sh[j]);
      end
    end
    br_out = prop ? br : br_ripple;
  end

  // Datapath. Operands are captured on accept and then consumed one block
  // per RUN cycle. The flags are loaded as the last block is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      br       <= 1'b0;
      idx      <= '0;
      skip_cnt <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= PAD_W'(a);
            b_sh     <= PAD_W'(b);
            diff_sh  <= '0;
            br       <= bin;
            idx      <= '0;
            skip_cnt <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> BLOCK_SIZE;
          b_sh    <= b_sh >> BLOCK_SIZE;
          diff_sh <= diff_next;
          br      <= br_out;
          idx     <= idx + 1'b1;
          if (prop) skip_cnt <= skip_cnt + 1'b1;
          if (last_blk) begin
            // The sign bits sit at LAST_W-1 of the final block.
            bout <= br_out;
            ovf  <= (a_sh[LAST_W-1] ^ b_sh[LAST_W-1]) & (a_sh[LAST_W-1] ^ slice_d[LAST_W-1]);
            zero <= ~|diff_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_serial_subtractor.sv
// tb_block_serial_subtractor
// Self-checking bench for block_serial_subtractor. It uses a 32/4 instance and a
// 10/4 instance that has a partial last block. Expected results come from a
// plain arithmetic model of a - b - bin.
module tb_block_serial_subtractor;

  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    logic [3:0]  skip;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  logic        bin_w, bout_w, ovf_w, zero_w;
  logic [31:0] a_w, b_w, diff_w;
  logic [3:0]  skip_w;

  // 10-bit instance signals
  logic        in_valid_n, in_ready_n, out_valid_n, out_ready_n;
  logic        bin_n, bout_n, ovf_n, zero_n;
  logic [9:0]  a_n, b_n, diff_n;
  logic [1:0]  skip_n;

  int checks = 0;
  int errors = 0;

  block_serial_subtractor #(.DATA_WIDTH(32), .BLOCK_SIZE(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .bin(bin_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .diff(diff_w), .bout(bout_w), .ovf(ovf_w), .zero(zero_w), .skip_cnt(skip_w)
  );

  block_serial_subtractor #(.DATA_WIDTH(10), .BLOCK_SIZE(4)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .a(a_n), .b(b_n), .bin(bin_n), .out_valid(out_valid_n), .out_ready(out_ready_n),
    .diff(diff_n), .bout(bout_n), .ovf(ovf_n), .zero(zero_n), .skip_cnt(skip_n)
  );

  // Reference model for a width of w bits with 4-bit blocks
  function automatic res_t model(input int w, input logic [31:0] ia, input logic [31:0] ib, input logic ibin);
    longint unsigned m, xa, xb, full, x;
    res_t r;
    m    = (64'd1 << w) - 64'd1;
    xa   = {32'b0, ia} & m;
    xb   = {32'b0, ib} & m;
    full = (xa - xb - {63'b0, ibin}) & m;
    r.diff = full[31:0];
    r.bout = (xa < (xb + {63'b0, ibin}));
    r.ovf  = (xa[w-1] ^ xb[w-1]) & (xa[w-1] ^ full[w-1]);
    r.zero = (full == 64'd0);
    r.skip = 4'd0;
    x = xa ^ xb;
    for (int k = 0; k * 4 < w; k++) begin
      if (((x >> (4 * k)) & 64'hF) == 64'd0) r.skip = r.skip + 4'd1;
    end
    return r;
  endfunction

  // Runs one operation on the selected instance and returns the observed
  // result and the latency from accept to out_valid (-1 on timeout)
  task automatic do_op(input bit narrow, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ibin, output res_t r, output int lat);
    int  n;
    bit  seen;
    @(negedge clk);
    out_ready_w = 1'b0;
    out_ready_n = 1'b0;
    if (narrow) begin
      a_n = ia[9:0]; b_n = ib[9:0]; bin_n = ibin; in_valid_n = 1'b1;
    end else begin
      a_w = ia; b_w = ib; bin_w = ibin; in_valid_w = 1'b1;
    end
    n = 0;
    while (!(narrow ? in_ready_n : in_ready_w) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    in_valid_n = 1'b0;
    lat  = -1;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (narrow ? out_valid_n : out_valid_w) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    if (narrow) begin
      r.diff = {22'b0, diff_n}; r.bout = bout_n; r.ovf = ovf_n; r.zero = zero_n; r.skip = {2'b0, skip_n};
    end else begin
      r.diff = diff_w; r.bout = bout_w; r.ovf = ovf_w; r.zero = zero_w; r.skip = skip_w;
    end
    out_ready_w = 1'b1;
    out_ready_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready_w = 1'b0;
    out_ready_n = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (in_ready_w !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready_w got %b exp 1", in_ready_w); end
    checks++; if (out_valid_w !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid_w got %b exp 0", out_valid_w); end
    checks++; if ({diff_w, bout_w, ovf_w, zero_w, skip_w} !== '0) begin errors++; $display("[TB] FAIL reset outputs_w got diff=%h b=%b o=%b z=%b s=%0d exp all 0", diff_w, bout_w, ovf_w, zero_w, skip_w); end
    checks++; if (in_ready_n !== 1'b1 || out_valid_n !== 1'b0) begin errors++; $display("[TB] FAIL reset handshake_n got in_ready=%b out_valid=%b exp 1/0", in_ready_n, out_valid_n); end
    checks++; if ({diff_n, bout_n, ovf_n, zero_n, skip_n} !== '0) begin errors++; $display("[TB] FAIL reset outputs_n got diff=%h s=%0d exp 0", diff_n, skip_n); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] va [8] = '{32'h5, 32'h0, 32'h80000000, 32'h12345678, 32'h12345678, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF};
    logic [31:0] vb [8] = '{32'h3, 32'h1, 32'h1,        32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic        vc [8] = '{1'b0,  1'b0,  1'b0,         1'b1,         1'b0,         1'b0,         1'b1,  1'b1};
    res_t got, exp;
    int   lat;
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, va[i], vb[i], vc[i], got, lat);
      exp = model(32, va[i], vb[i], vc[i]);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL directed[%0d] result got d=%h b=%b o=%b z=%b s=%0d exp d=%h b=%b o=%b z=%b s=%0d",
                 i, got.diff, got.bout, got.ovf, got.zero, got.skip, exp.diff, exp.bout, exp.ovf, exp.zero, exp.skip);
      end
      checks++;
      if (lat !== 8) begin errors++; $display("[TB] FAIL directed[%0d] latency got %0d exp 8", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, mask;
    logic        rc;
    res_t        got, exp;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: rb = $urandom;
        1: begin
          // differ only in a random subset of blocks
          mask = '0;
          for (int k = 0; k < 8; k++) if ($urandom_range(0, 1) == 1) mask[4*k +: 4] = 4'($urandom_range(1, 15));
          rb = ra ^ mask;
        end
        default: rb = ra;
      endcase
      do_op(1'b0, ra, rb, rc, got, lat);
      exp = model(32, ra, rb, rc);
      checks++;
      if (got !== exp || lat !== 8) begin
        errors++;
        $display("[TB] FAIL random[%0d] a=%h b=%h bin=%b got d=%h b=%b o=%b z=%b s=%0d lat=%0d exp d=%h b=%b o=%b z=%b s=%0d lat=8",
                 i, ra, rb, rc, got.diff, got.bout, got.ovf, got.zero, got.skip, lat, exp.diff, exp.bout, exp.ovf, exp.zero, exp.skip);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t        exp1, exp2;
    logic [31:0] a2, b2;
    int          n, lat;
    bit          seen;
    exp1 = model(32, 32'hCAFE0000, 32'h0000BEEF, 1'b1);
    a2 = $urandom;
    b2 = $urandom;
    exp2 = model(32, a2, b2, 1'b0);
    @(negedge clk);
    a_w = 32'hCAFE0000; b_w = 32'h0000BEEF; bin_w = 1'b1; in_valid_w = 1'b1; out_ready_w = 1'b0;
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    n = 0;
    while (!out_valid_w && n < 40) begin @(posedge clk); #1; n++; end
    // hold DONE while new operands are presented and withdrawn
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_w = $urandom; b_w = $urandom; bin_w = 1'($urandom_range(0, 1)); in_valid_w = i[0];
      checks++;
      if (out_valid_w !== 1'b1 || in_ready_w !== 1'b0 || diff_w !== exp1.diff || bout_w !== exp1.bout ||
          ovf_w !== exp1.ovf || zero_w !== exp1.zero || skip_w !== exp1.skip) begin
        errors++;
        $display("[TB] FAIL hold[%0d] got ov=%b ir=%b d=%h b=%b o=%b z=%b s=%0d exp ov=1 ir=0 d=%h b=%b o=%b z=%b s=%0d",
                 i, out_valid_w, in_ready_w, diff_w, bout_w, ovf_w, zero_w, skip_w, exp1.diff, exp1.bout, exp1.ovf, exp1.zero, exp1.skip);
      end
    end
    @(negedge clk);
    a_w = a2; b_w = b2; bin_w = 1'b0; in_valid_w = 1'b1; out_ready_w = 1'b1;
    @(posedge clk);
    #1;
    out_ready_w = 1'b0;
    checks++;
    if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release handshake got in_ready=%b out_valid=%b exp 1/0", in_ready_w, out_valid_w);
    end
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    lat = -1; seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (out_valid_w) begin seen = 1'b1; lat = n; end
    end
    checks++;
    if (diff_w !== exp2.diff || bout_w !== exp2.bout || ovf_w !== exp2.ovf || zero_w !== exp2.zero ||
        skip_w !== exp2.skip || lat !== 8) begin
      errors++;
      $display("[TB] FAIL pending result got d=%h b=%b s=%0d lat=%0d exp d=%h b=%b s=%0d lat=8",
               diff_w, bout_w, skip_w, lat, exp2.diff, exp2.bout, exp2.skip);
    end
    @(negedge clk);
    out_ready_w = 1'b1;
    @(posedge clk);
    #1;
    out_ready_w = 1'b0;
  endtask

  task automatic test_reset_inflight();
    int n;
    // reset three cycles into RUN
    @(negedge clk);
    a_w = 32'h0F0F0F0F; b_w = 32'h0F0F0F00; bin_w = 1'b0; in_valid_w = 1'b1;
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0 || {diff_w, bout_w, ovf_w, zero_w, skip_w} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_run got ir=%b ov=%b d=%h b=%b s=%0d exp ir=1 ov=0 all 0", in_ready_w, out_valid_w, diff_w, bout_w, skip_w);
    end
    @(negedge clk);
    rst = 1'b0;
    // reset while a result waits in DONE
    @(negedge clk);
    a_w = 32'h0; b_w = 32'h1; bin_w = 1'b0; in_valid_w = 1'b1; out_ready_w = 1'b0;
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    n = 0;
    while (!out_valid_w && n < 40) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0 || {diff_w, bout_w, ovf_w, zero_w, skip_w} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_done got ir=%b ov=%b d=%h b=%b s=%0d exp ir=1 ov=0 all 0", in_ready_w, out_valid_w, diff_w, bout_w, skip_w);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_partial();
    logic [31:0] pa [3] = '{32'h3FF, 32'h155, 32'h000};
    logic [31:0] pb [3] = '{32'h001, 32'h055, 32'h200};
    logic        pc [3] = '{1'b0,    1'b0,    1'b1};
    res_t got, exp;
    int   lat;
    for (int i = 0; i < 9; i++) begin
      logic [31:0] xa, xb;
      logic        xc;
      if (i < 3) begin
        xa = pa[i]; xb = pb[i]; xc = pc[i];
      end else begin
        xa = {22'b0, 10'($urandom)};
        xb = (i[0]) ? {22'b0, 10'($urandom)} : (xa ^ {22'b0, 2'($urandom), 8'h00});
        xc = 1'($urandom_range(0, 1));
      end
      do_op(1'b1, xa, xb, xc, got, lat);
      exp = model(10, xa, xb, xc);
      checks++;
      if (got !== exp || lat !== 3) begin
        errors++;
        $display("[TB] FAIL partial[%0d] a=%h b=%h bin=%b got d=%h b=%b o=%b z=%b s=%0d lat=%0d exp d=%h b=%b o=%b z=%b s=%0d lat=3",
                 i, xa[9:0], xb[9:0], xc, got.diff, got.bout, got.ovf, got.zero, got.skip, lat, exp.diff, exp.bout, exp.ovf, exp.zero, exp.skip);
      end
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    in_valid_w = 1'b0; out_ready_w = 1'b0; a_w = '0; b_w = '0; bin_w = 1'b0;
    in_valid_n = 1'b0; out_ready_n = 1'b0; a_n = '0; b_n = '0; bin_n = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    test_partial();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
